// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcode and stage-state types for the execute/writeback stage
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int SHAMT_W   = $clog2(DATA_W);

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } ewb_state_t;

endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - decoded-instruction handshake bus into the execute/writeback stage
interface alu_writeback_if;
  import cpu_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  alu_op_t              instr_op;
  logic [REG_IDX_W-1:0] instr_dst;
  logic [REG_IDX_W-1:0] instr_src_a;
  logic [REG_IDX_W-1:0] instr_src_b;
  logic                 instr_use_imm;
  logic [DATA_W-1:0]    instr_imm;

  modport master (
    output instr_valid, instr_op, instr_dst, instr_src_a, instr_src_b,
           instr_use_imm, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_dst, instr_src_a, instr_src_b,
           instr_use_imm, instr_imm,
    output instr_ready
  );

endinterface

// File: rtl/shift_add_mul8.sv
// rtl/shift_add_mul8.sv - 8-cycle iterative shift-add 8x8->16 multiplier
module shift_add_mul8
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] product
);

  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                busy_q;

  // product is the accumulator plus this cycle's partial term, so it is final while done is high
  always_comb begin
    product = acc_q + (mplier_q[0] ? mcand_q : '0);
    done    = busy_q && (cnt_q == SHAMT_W'(DATA_W - 1));
    busy    = busy_q;
  end

  // load operands on start, then add one shifted partial product per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start && !busy_q) begin
      mcand_q  <= {{DATA_W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - execute/writeback stage: operand latch, ALU, multiplier, flags, one-hot write
module alu_writeback
  import cpu_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  alu_writeback_if.slave                   instr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_rd,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_wr,
  output logic [NUM_REGS-1:0]              write_en,
  output logic                             flag_z,
  output logic                             flag_c
);

  ewb_state_t           state_q, state_d;
  alu_op_t              op_q;
  logic [REG_IDX_W-1:0] dst_q;
  logic [DATA_W-1:0]    a_q, b_q;

  logic                 ready_c, accept, load_result, mul_start;
  logic [DATA_W-1:0]    operand_a, operand_b;
  logic                 mul_busy, mul_done;
  logic [2*DATA_W-1:0]  mul_product;
  logic [DATA_W:0]      sum, diff;
  logic [2*DATA_W-1:0]  shl_full;
  logic [DATA_W-1:0]    res_r;
  logic                 res_c;

  assign instr.instr_ready = ready_c;
  assign accept    = instr.instr_valid && ready_c;
  assign operand_a = regs_rd[instr.instr_src_a];
  assign operand_b = instr.instr_use_imm ? instr.instr_imm : regs_rd[instr.instr_src_b];

  shift_add_mul8 u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // stage sequencing: accept in IDLE, one EXEC or eight MUL cycles, then a single WB cycle
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    write_en    = '0;
    load_result = 1'b0;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = rst_n;
        if (accept) begin
          if (instr.instr_op == OP_MUL) begin
            mul_start = !mul_busy;
            state_d   = ST_MUL;
          end else begin
            state_d   = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        load_result = 1'b1;
        state_d     = ST_WB;
      end
      ST_MUL: begin
        if (mul_done) begin
          load_result = 1'b1;
          state_d     = ST_WB;
        end
      end
      ST_WB: begin
        write_en = NUM_REGS'(1) << dst_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // result and carry for the latched instruction; the shift's carry is the bit that lands just above the byte
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    shl_full = {{DATA_W{1'b0}}, a_q} << b_q[SHAMT_W-1:0];
    res_r    = '0;
    res_c    = 1'b0;
    case (op_q)
      OP_MOV: res_r = b_q;
      OP_ADD: begin res_r = sum[DATA_W-1:0];  res_c = sum[DATA_W];  end
      OP_SUB: begin res_r = diff[DATA_W-1:0]; res_c = diff[DATA_W]; end
      OP_AND: res_r = a_q & b_q;
      OP_OR:  res_r = a_q | b_q;
      OP_XOR: res_r = a_q ^ b_q;
      OP_SHL: begin
        res_r = shl_full[DATA_W-1:0];
        res_c = (b_q[SHAMT_W-1:0] != '0) && shl_full[DATA_W];
      end
      OP_MUL: begin
        res_r = mul_product[DATA_W-1:0];
        res_c = |mul_product[2*DATA_W-1:DATA_W];
      end
      default: res_r = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // operand latch: fields only need to be valid on the accept edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= OP_MOV;
      dst_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      op_q  <= instr.instr_op;
      dst_q <= instr.instr_dst;
      a_q   <= operand_a;
      b_q   <= operand_b;
    end
  end

  // result lanes and flags update on entry to WB and hold until the next result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_wr <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else if (load_result) begin
      regs_wr <= {NUM_REGS{res_r}};
      flag_z  <= (res_r == '0);
      flag_c  <= res_c;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for the execute/writeback stage with a register-file model
module tb_alu_writeback;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_writeback_if bus ();

  logic [3:0][7:0] rf = {8'd16, 8'd8, 8'd4, 8'd2};
  logic [3:0][7:0] regs_wr;
  logic [3:0]      write_en;
  logic            flag_z, flag_c;

  alu_writeback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (bus),
    .regs_rd  (rf),
    .regs_wr  (regs_wr),
    .write_en (write_en),
    .flag_z   (flag_z),
    .flag_c   (flag_c)
  );

  // register file: captures each strobed lane at the end of the WB cycle
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (write_en[i]) rf[i] <= regs_wr[i];
  end

  int n_pass = 0;
  int n_total = 0;
  int ref_regs [4] = '{2, 4, 8, 16};

  typedef struct {
    int op, dst, sa, sb, ui, imm, r, z, c;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // reference arithmetic straight from the op definitions; returns {carry, result}
  function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
    int   r;
    int   s;
    logic c;
    c = 1'b0;
    case (op)
      0: r = b;
      1: begin r = a + b; c = (r > 255); end
      2: begin r = a - b; c = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin s = b % 8; r = a * (1 << s); c = (s != 0) && (((r >> 8) & 1) == 1); end
      default: begin r = a * b; c = (r > 255); end
    endcase
    return {c, 8'(r)};
  endfunction

  task automatic drive(input int op, input int dst, input int sa, input int sb, input int ui, input int imm);
    bus.instr_op      = alu_op_t'(3'(op));
    bus.instr_dst     = 2'(dst);
    bus.instr_src_a   = 2'(sa);
    bus.instr_src_b   = 2'(sb);
    bus.instr_use_imm = 1'(ui);
    bus.instr_imm     = 8'(imm);
    bus.instr_valid   = 1'b1;
  endtask

  task automatic issue(input string nm, input int op, input int dst, input int sa, input int sb,
                       input int ui, input int imm, input int exp_r, input int exp_z, input int exp_c);
    int         waited;
    int         lat;
    int         early;
    logic [7:0] e8;
    waited = 0;
    early  = 0;
    lat    = (op == 7) ? 9 : 2;
    e8     = 8'(exp_r);
    @(negedge clk); #1;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check({nm, "_ready"}, 32'(bus.instr_ready), 32'd1);
    drive(op, dst, sa, sb, ui, imm);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k < lat) begin
        if (write_en != 4'd0) early++;
      end else begin
        check({nm, "_write_en"}, 32'(write_en), 32'(4'd1 << dst));
        check({nm, "_result"}, 32'(regs_wr), 32'({4{e8}}));
        check({nm, "_z"}, 32'(flag_z), 32'(exp_z));
        check({nm, "_c"}, 32'(flag_c), 32'(exp_c));
      end
    end
    check({nm, "_early_we"}, 32'(early), 32'd0);
    @(negedge clk);
    check({nm, "_we_off"}, 32'(write_en), 32'd0);
    check({nm, "_rf"}, 32'(rf[dst]), 32'(e8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0][7:0] snap;
    logic [8:0]      rdy_pat;
    logic            r_now;
    logic [8:0]      m;
    int              bad, nacc;
    int              op, dst, sa, sb, ui, imm, bval;

    bus.instr_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.instr_valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 32'(bus.instr_ready), 32'd1);
    check("reset_we", 32'(write_en), 32'd0);
    check("reset_regs_wr", 32'(regs_wr), 32'd0);
    check("reset_z", 32'(flag_z), 32'd0);
    check("reset_c", 32'(flag_c), 32'd0);

    //           op dst sa sb ui imm    r     z  c
    tbl[0]  = '{1, 0, 0, 1, 0, 0,    6,    0, 0};
    tbl[1]  = '{2, 1, 1, 0, 1, 4,    0,    1, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 2,    2,    0, 0};
    tbl[3]  = '{2, 1, 0, 0, 1, 4,    'hFE, 0, 1};
    tbl[4]  = '{7, 3, 3, 0, 1, 16,   0,    1, 1};
    tbl[5]  = '{7, 0, 2, 0, 1, 3,    'h18, 0, 0};
    tbl[6]  = '{0, 2, 0, 0, 1, 'h81, 'h81, 0, 0};
    tbl[7]  = '{6, 3, 2, 0, 1, 1,    'h02, 0, 1};
    tbl[8]  = '{6, 1, 2, 0, 1, 8,    'h81, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 1,    1,    0, 0};
    tbl[10] = '{6, 0, 0, 0, 1, 7,    'h80, 0, 0};
    tbl[11] = '{3, 2, 0, 1, 0, 0,    'h80, 0, 0};
    tbl[12] = '{4, 3, 3, 0, 0, 0,    'h82, 0, 0};
    tbl[13] = '{5, 1, 1, 1, 0, 0,    0,    1, 0};
    tbl[14] = '{1, 0, 0, 0, 1, 'h80, 0,    1, 1};
    tbl[15] = '{1, 3, 3, 3, 0, 0,    4,    0, 1};
    for (int i = 0; i < 16; i++) begin
      issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb,
            tbl[i].ui, tbl[i].imm, tbl[i].r, tbl[i].z, tbl[i].c);
      ref_regs[tbl[i].dst] = tbl[i].r;
    end

    // reset pulse while the multiplier is on iteration 4: no write, flags and lanes cleared
    snap = rf;
    bad  = 0;
    @(negedge clk); #1;
    check("mulrst_ready", 32'(bus.instr_ready), 32'd1);
    drive(7, 2, 3, 0, 1, 5);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (write_en != 4'd0) bad++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mulrst_ready_in_reset", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("mulrst_ready_after", 32'(bus.instr_ready), 32'd1);
    check("mulrst_z", 32'(flag_z), 32'd0);
    check("mulrst_c", 32'(flag_c), 32'd0);
    check("mulrst_regs_wr", 32'(regs_wr), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (write_en != 4'd0) bad++;
    end
    check("mulrst_no_write", 32'(bad), 32'd0);
    check("mulrst_rf", 32'(snap), 32'(rf));

    // three back-to-back dependent ADDs with valid held high
    issue("seed_r0", 0, 0, 0, 0, 1, 3, 3, 0, 0);
    ref_regs[0] = 3;
    @(negedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    nacc    = 0;
    bad     = 0;
    rdy_pat = '0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk); #1;
      end
      rdy_pat[cyc] = bus.instr_ready;
      if (write_en != ((cyc % 3 == 2) ? 4'd1 : 4'd0)) bad++;
      if (cyc % 3 == 2)
        check($sformatf("queued_result%0d", cyc / 3), 32'(regs_wr[0]), 32'(3 << (cyc / 3 + 1)));
      r_now = bus.instr_ready;
      @(posedge clk); #1;
      if (r_now) begin
        nacc++;
        if (nacc == 3) bus.instr_valid = 1'b0;
      end
    end
    check("queued_ready_pattern", 32'(rdy_pat), 32'(9'b001001001));
    check("queued_we_pattern", 32'(bad), 32'd0);
    @(negedge clk);
    check("queued_rf", 32'(rf[0]), 32'd24);
    ref_regs[0] = 24;

    // random instructions against the reference arithmetic
    for (int i = 0; i < 40; i++) begin
      op   = int'($urandom_range(0, 7));
      dst  = int'($urandom_range(0, 3));
      sa   = int'($urandom_range(0, 3));
      sb   = int'($urandom_range(0, 3));
      ui   = int'($urandom_range(0, 1));
      imm  = int'($urandom_range(0, 255));
      bval = (ui != 0) ? imm : ref_regs[sb];
      m    = ref_alu(op, ref_regs[sa], bval);
      issue($sformatf("rand%0d_op%0d", i, op), op, dst, sa, sb, ui, imm,
            int'(m[7:0]), (m[7:0] == 8'd0) ? 1 : 0, int'(m[8]));
      ref_regs[dst] = int'(m[7:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
